arc4_crack_ctrl: RTL

- Key-search sequencer for the ARC4 cracking datapath.
- For each candidate 24-bit key, runs the init, KSA and PRGA engines in order and owns the S-memory and PT-memory port muxes between them.
- Scans the decrypted plaintext for printable ASCII, then either reports the key or advances to the next candidate.
- Sits between the top level (start/result) and the three engines; multiple instances can partition the key space via parameters.

---
 rtl/arc4_pkg.sv | 30 +++
 rtl/arc4_port_mux.sv | 56 +++++
 rtl/arc4_crack_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 key-search controller and its port mux.
package arc4_pkg;

  localparam int         KEY_W        = 24;
  localparam logic [7:0] PRINT_LO_DEF = 8'h20;
  localparam logic [7:0] PRINT_HI_DEF = 8'h7E;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_INIT_GO, ST_INIT_ACK, ST_INIT_WAIT,
    ST_KSA_GO,  ST_KSA_ACK,  ST_KSA_WAIT,
    ST_PRGA_GO, ST_PRGA_ACK, ST_PRGA_WAIT,
    ST_LEN_RD,  ST_LEN_LAT,
    ST_CHK_RD,  ST_CHK_LAT,
    ST_NEXT_KEY, ST_FOUND, ST_DONE
  } state_e;

  typedef enum logic [1:0] {SEL_NONE, SEL_INIT, SEL_KSA, SEL_PRGA} eng_sel_e;

  // Which engine owns the shared memory ports in a given controller state.
  function automatic eng_sel_e phase_sel(state_e s);
    case (s)
      ST_INIT_GO, ST_INIT_ACK, ST_INIT_WAIT: return SEL_INIT;
      ST_KSA_GO,  ST_KSA_ACK,  ST_KSA_WAIT:  return SEL_KSA;
      ST_PRGA_GO, ST_PRGA_ACK, ST_PRGA_WAIT: return SEL_PRGA;
      default:                               return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arc4_port_mux.sv
// Combinational S-memory / PT-memory port selection between the three engines
// and the controller's plaintext scan.
module arc4_port_mux
  import arc4_pkg::*;
(
  input  eng_sel_e   sel_i,
  input  logic       scan_i,
  input  logic [7:0] scan_addr_i,
  input  logic [7:0] init_s_addr_i, init_s_wrdata_i,
  input  logic       init_s_wren_i,
  input  logic [7:0] ksa_s_addr_i, ksa_s_wrdata_i,
  input  logic       ksa_s_wren_i,
  input  logic [7:0] prga_s_addr_i, prga_s_wrdata_i,
  input  logic       prga_s_wren_i,
  input  logic [7:0] prga_pt_addr_i, prga_pt_wrdata_i,
  input  logic       prga_pt_wren_i,
  output logic [7:0] s_addr_o, s_wrdata_o,
  output logic       s_wren_o,
  output logic [7:0] pt_addr_o, pt_wrdata_o,
  output logic       pt_wren_o
);

  always_comb begin
    s_addr_o    = 8'd0;
    s_wrdata_o  = 8'd0;
    s_wren_o    = 1'b0;
    pt_addr_o   = 8'd0;
    pt_wrdata_o = 8'd0;
    pt_wren_o   = 1'b0;
    case (sel_i)
      SEL_INIT: begin
        s_addr_o   = init_s_addr_i;
        s_wrdata_o = init_s_wrdata_i;
        s_wren_o   = init_s_wren_i;
      end
      SEL_KSA: begin
        s_addr_o   = ksa_s_addr_i;
        s_wrdata_o = ksa_s_wrdata_i;
        s_wren_o   = ksa_s_wren_i;
      end
      SEL_PRGA: begin
        s_addr_o    = prga_s_addr_i;
        s_wrdata_o  = prga_s_wrdata_i;
        s_wren_o    = prga_s_wren_i;
        pt_addr_o   = prga_pt_addr_i;
        pt_wrdata_o = prga_pt_wrdata_i;
        pt_wren_o   = prga_pt_wren_i;
      end
      default: begin
        // The scan only ever reads PT memory.
        if (scan_i) pt_addr_o = scan_addr_i;
      end
    endcase
  end

endmodule

// File: rtl/arc4_crack_ctrl.sv
// ARC4 key-search sequencer: runs init/KSA/PRGA per candidate key, scans plaintext for printable bytes.
// Optional keys_tried statistics counter built only when ARC4_CRACK_STATS_EN is defined.
module arc4_crack_ctrl
  import arc4_pkg::*;
#(
  parameter logic [KEY_W-1:0] KEY_FIRST = 24'h000000,
  parameter logic [KEY_W-1:0] KEY_STEP  = 24'h000001,
  parameter logic [7:0]       PRINT_LO  = PRINT_LO_DEF,
  parameter logic [7:0]       PRINT_HI  = PRINT_HI_DEF
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  output logic             key_found,
  output logic [KEY_W-1:0] key_out,
  output logic [KEY_W-1:0] cur_key,
  output logic             init_en,
  output logic             ksa_en,
  output logic             prga_en,
  input  logic             init_rdy,
  input  logic             ksa_rdy,
  input  logic             prga_rdy,
  input  logic [7:0]       init_s_addr,
  input  logic [7:0]       init_s_wrdata,
  input  logic             init_s_wren,
  input  logic [7:0]       ksa_s_addr,
  input  logic [7:0]       ksa_s_wrdata,
  input  logic             ksa_s_wren,
  input  logic [7:0]       prga_s_addr,
  input  logic [7:0]       prga_s_wrdata,
  input  logic             prga_s_wren,
  output logic [7:0]       s_addr,
  output logic [7:0]       s_wrdata,
  output logic             s_wren,
  input  logic [7:0]       prga_pt_addr,
  input  logic [7:0]       prga_pt_wrdata,
  input  logic             prga_pt_wren,
  output logic [7:0]       pt_addr,
  output logic [7:0]       pt_wrdata,
  output logic             pt_wren,
  input  logic [7:0]       pt_rddata,
  output logic [KEY_W-1:0] keys_tried
);

  state_e           state_q;
  logic             rdy_q, key_found_q;
  logic [KEY_W-1:0] key_out_q, cur_key_q;
  logic             init_en_q, ksa_en_q, prga_en_q;
  logic [7:0]       len_q, idx_q;
  logic [KEY_W:0]   key_sum;
  logic             start;
  logic             byte_bad;

  assign key_sum  = {1'b0, cur_key_q} + {1'b0, KEY_STEP};
  assign start    = (state_q == ST_IDLE || state_q == ST_DONE) && en;
  assign byte_bad = (pt_rddata < PRINT_LO) || (pt_rddata > PRINT_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rdy_q       <= 1'b1;
      key_found_q <= 1'b0;
      key_out_q   <= '0;
      cur_key_q   <= KEY_FIRST;
      init_en_q   <= 1'b0;
      ksa_en_q    <= 1'b0;
      prga_en_q   <= 1'b0;
      len_q       <= 8'd0;
      idx_q       <= 8'd0;
    end else begin
      init_en_q <= 1'b0;
      ksa_en_q  <= 1'b0;
      prga_en_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (en) begin
            cur_key_q   <= KEY_FIRST;
            rdy_q       <= 1'b0;
            key_found_q <= 1'b0;
            init_en_q   <= 1'b1;
            state_q     <= ST_INIT_GO;
          end
        end
        // Each phase: pulse, then require rdy to drop before accepting it high again.
        ST_INIT_GO:   state_q <= ST_INIT_ACK;
        ST_INIT_ACK:  if (!init_rdy) state_q <= ST_INIT_WAIT;
        ST_INIT_WAIT: if (init_rdy) begin
          ksa_en_q <= 1'b1;
          state_q  <= ST_KSA_GO;
        end
        ST_KSA_GO:    state_q <= ST_KSA_ACK;
        ST_KSA_ACK:   if (!ksa_rdy) state_q <= ST_KSA_WAIT;
        ST_KSA_WAIT:  if (ksa_rdy) begin
          prga_en_q <= 1'b1;
          state_q   <= ST_PRGA_GO;
        end
        ST_PRGA_GO:   state_q <= ST_PRGA_ACK;
        ST_PRGA_ACK:  if (!prga_rdy) state_q <= ST_PRGA_WAIT;
        ST_PRGA_WAIT: if (prga_rdy) state_q <= ST_LEN_RD;
        ST_LEN_RD:    state_q <= ST_LEN_LAT;
        ST_LEN_LAT: begin
          len_q   <= pt_rddata;
          idx_q   <= 8'd1;
          state_q <= (pt_rddata == 8'd0) ? ST_FOUND : ST_CHK_RD;
        end
        ST_CHK_RD:    state_q <= ST_CHK_LAT;
        ST_CHK_LAT: begin
          if (byte_bad) begin
            state_q <= ST_NEXT_KEY;
          end else if (idx_q == len_q) begin
            state_q <= ST_FOUND;
          end else begin
            idx_q   <= idx_q + 8'd1;
            state_q <= ST_CHK_RD;
          end
        end
        ST_NEXT_KEY: begin
          if (key_sum[KEY_W]) begin
            key_found_q <= 1'b0;
            key_out_q   <= cur_key_q;
            rdy_q       <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            cur_key_q <= key_sum[KEY_W-1:0];
            init_en_q <= 1'b1;
            state_q   <= ST_INIT_GO;
          end
        end
        ST_FOUND: begin
          key_found_q <= 1'b1;
          key_out_q   <= cur_key_q;
          rdy_q       <= 1'b1;
          state_q     <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rdy       = rdy_q;
  assign key_found = key_found_q;
  assign key_out   = key_out_q;
  assign cur_key   = cur_key_q;
  assign init_en   = init_en_q;
  assign ksa_en    = ksa_en_q;
  assign prga_en   = prga_en_q;

  arc4_port_mux u_mux (
    .sel_i           (phase_sel(state_q)),
    .scan_i          (state_q inside {ST_LEN_RD, ST_LEN_LAT, ST_CHK_RD, ST_CHK_LAT}),
    .scan_addr_i     ((state_q inside {ST_CHK_RD, ST_CHK_LAT}) ? idx_q : 8'd0),
    .init_s_addr_i   (init_s_addr),
    .init_s_wrdata_i (init_s_wrdata),
    .init_s_wren_i   (init_s_wren),
    .ksa_s_addr_i    (ksa_s_addr),
    .ksa_s_wrdata_i  (ksa_s_wrdata),
    .ksa_s_wren_i    (ksa_s_wren),
    .prga_s_addr_i   (prga_s_addr),
    .prga_s_wrdata_i (prga_s_wrdata),
    .prga_s_wren_i   (prga_s_wren),
    .prga_pt_addr_i  (prga_pt_addr),
    .prga_pt_wrdata_i(prga_pt_wrdata),
    .prga_pt_wren_i  (prga_pt_wren),
    .s_addr_o        (s_addr),
    .s_wrdata_o      (s_wrdata),
    .s_wren_o        (s_wren),
    .pt_addr_o       (pt_addr),
    .pt_wrdata_o     (pt_wrdata),
    .pt_wren_o       (pt_wren)
  );

`ifdef ARC4_CRACK_STATS_EN
  logic [KEY_W-1:0] keys_tried_q;

  // NEXT_KEY and FOUND each last exactly one cycle per visit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_tried_q <= '0;
    end else if (start) begin
      keys_tried_q <= '0;
    end else if ((state_q == ST_NEXT_KEY || state_q == ST_FOUND) && keys_tried_q != '1) begin
      keys_tried_q <= keys_tried_q + 1'b1;
    end
  end

  assign keys_tried = keys_tried_q;
`else
  assign keys_tried = '0;
`endif

endmodule
